cache_arbiter: RTL
==================

CACHE_ARBITER -- requirements
Module: cache_arbiter

Parameters
REQ-001 The block SHALL have parameter LINE_W, default 256, meaning cache line / memory burst width in bits.
REQ-002 The block SHALL have parameter STARVE_MAX, default 2, meaning consecutive D grants allowed while I waits.

Interface
REQ-003 The block SHALL have port clk, input, 1, the single clock.
REQ-004 The block SHALL have port rst, input, 1, synchronous active-high reset sampled on rising clk.
REQ-005 The block SHALL have ports i_read, input, 1, and i_address, input, 32, the I-cache line read request, held until i_resp.
REQ-006 The block SHALL have ports i_rdata, output, LINE_W, and i_resp, output, 1, the I-cache read data and completion pulse.
REQ-007 The block SHALL have ports d_read, d_write, input, 1 each, and d_address, input, 32, the D-cache line request, held until d_resp.
REQ-008 The block SHALL have ports d_wdata, input, LINE_W; d_rdata, output, LINE_W; d_resp, output, 1.
REQ-009 The block SHALL have ports pmem_read, pmem_write, output, 1 each, and pmem_address, output, 32, to physical memory.
REQ-010 The block SHALL have ports pmem_wdata, output, LINE_W; pmem_rdata, input, LINE_W; pmem_resp, input, 1.

Function
REQ-011 The FSM SHALL have states IDLE, SERVE_I, SERVE_D.
- IDLE: no pmem_read/pmem_write; arbitrate.
- SERVE_I/SERVE_D: drive memory from latched request until pmem_resp.
REQ-012 From IDLE, the FSM SHALL enter SERVE_D if d_read|d_write, unless i_read && starve_cnt==STARVE_MAX, in which case it SHALL enter SERVE_I.
REQ-013 From IDLE with only i_read, the FSM SHALL enter SERVE_I.
REQ-014 On entering SERVE_x, the block SHALL latch address, direction and d_wdata, and drive pmem_* from latches only.
REQ-015 A late requester change SHALL NOT alter an in-flight transaction.
REQ-016 If d_read and d_write are both high at grant, the block SHALL service it as a write.
REQ-017 In SERVE_x with pmem_resp=1, the block SHALL assert x_resp in that cycle.
REQ-018 x_rdata SHALL equal pmem_rdata combinationally.
REQ-019 The FSM SHALL return to IDLE on the next edge.
REQ-020 The mandatory IDLE cycle SHALL prevent regranting a request its owner drops after resp.
REQ-021 x_resp SHALL be 0 whenever the state is not SERVE_x.
REQ-022 The block SHALL NOT assert both resps in one cycle.
REQ-023 pmem_resp in IDLE SHALL be ignored.
REQ-024 starve_cnt:
- 2-bit.
- Increments on each D grant while i_read is high.
- Clears on any I grant, or on a D grant with i_read low.
- Saturates at STARVE_MAX.
REQ-025 Minimum transaction latency, request-to-resp, SHALL be 2 cycles.
- 1 cycle IDLE grant.
- >=1 cycle in SERVE with memory responding immediately.
REQ-026 Throughput SHALL be one transaction per (memory latency + 1) cycles.

Reset
REQ-027 Reset SHALL force:
- state=IDLE, starve_cnt=0.
- Latches cleared.
- pmem_read=pmem_write=0, i_resp=d_resp=0 in the cycle after the reset edge.
REQ-028 Reset mid-transaction SHALL abandon it: no resp issued, no retry; requesters re-request.

Structure
REQ-029 The arb_state_t enum (IDLE, SERVE_I, SERVE_D) and the LINE_W default SHALL live in the shared rv32i_types package.
REQ-030 The block SHALL be a single module, with no sub-module.
REQ-031 State and latches SHALL be in one always_ff; next-state and outputs in always_comb.

Verification
REQ-032 Scenario: i_read, i_address=0x0000_0040, memory responds after 3 cycles with rdata=pattern A.
- pmem_read=1, pmem_address=0x40 for 3 cycles.
- i_resp one cycle, i_rdata=A.
- FSM IDLE next.
REQ-033 Scenario: i_read and d_read raised together at 0x100 / 0x200.
- D served first (pmem_address=0x200).
- IDLE cycle, then I served (0x100).
REQ-034 Scenario: i_read held, D requests back-to-back (3 writes).
- Two D writes granted, then I granted, then the third D write.
REQ-035 Scenario: d_write at 0x80, wdata=B; d_address changed to 0x90 mid-transaction.
- pmem_address stays 0x80, pmem_wdata=B, pmem_write=1 until pmem_resp.
REQ-036 Scenario: rst asserted during SERVE_D.
- Next cycle pmem_read/pmem_write=0, no d_resp, state IDLE.
- A stray pmem_resp afterwards produces no resp.
REQ-037 Scenario: d_read and d_write both high.
- pmem_write=1, pmem_read=0.

Source files
------------

// File: rtl/cache_arbiter_pkg.sv
// Shared types for the RV32I memory hierarchy: arbiter state encoding and
// the default cache-line width used by the caches and the arbiter.
package rv32i_types;

    localparam int LINE_W_DEFAULT = 256;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SERVE_I = 2'd1,
        SERVE_D = 2'd2
    } arb_state_t;

endpackage

// File: rtl/cache_arbiter.sv
// Two-port cache arbiter: multiplexes I-cache line reads and D-cache line
// reads/writes onto one physical-memory port. D has priority, but I is let
// through once D has been granted STARVE_MAX times in a row while I waited.
// Each transaction drives memory only from values latched at grant, and an
// IDLE cycle always separates transactions.
module cache_arbiter
    import rv32i_types::*;
#(
    parameter int LINE_W     = LINE_W_DEFAULT,
    parameter int STARVE_MAX = 2
) (
    input  logic              clk,
    input  logic              rst,
    // I-cache side
    input  logic              i_read,
    input  logic [31:0]       i_address,
    output logic [LINE_W-1:0] i_rdata,
    output logic              i_resp,
    // D-cache side
    input  logic              d_read,
    input  logic              d_write,
    input  logic [31:0]       d_address,
    input  logic [LINE_W-1:0] d_wdata,
    output logic [LINE_W-1:0] d_rdata,
    output logic              d_resp,
    // physical memory side
    output logic              pmem_read,
    output logic              pmem_write,
    output logic [31:0]       pmem_address,
    output logic [LINE_W-1:0] pmem_wdata,
    input  logic [LINE_W-1:0] pmem_rdata,
    input  logic              pmem_resp
);

    localparam logic [1:0] STARVE_LIM = 2'(STARVE_MAX);

    arb_state_t        r_state;
    arb_state_t        w_next;
    logic [31:0]       r_addr;
    logic              r_write;
    logic [LINE_W-1:0] r_wdata;
    logic [1:0]        r_starve;

    logic              w_d_req;
    logic              w_i_forced;
    logic              w_grant_d;
    logic              w_grant_i;
    logic [1:0]        w_starve_inc;

    assign w_d_req      = d_read | d_write;
    // I overrides D only once D has used up its run of consecutive grants
    assign w_i_forced   = i_read && (r_starve == STARVE_LIM);
    assign w_grant_d    = (r_state == IDLE) && (w_next == SERVE_D);
    assign w_grant_i    = (r_state == IDLE) && (w_next == SERVE_I);
    assign w_starve_inc = (r_starve == STARVE_LIM) ? r_starve : r_starve + 2'd1;

    // State, request latches and starvation counter
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= IDLE;
            r_addr   <= '0;
            r_write  <= 1'b0;
            r_wdata  <= '0;
            r_starve <= '0;
        end else begin
            r_state <= w_next;
            if (w_grant_d) begin
                r_addr   <= d_address;
                // read+write together is serviced as a write
                r_write  <= d_write;
                r_wdata  <= d_wdata;
                r_starve <= i_read ? w_starve_inc : 2'd0;
            end else if (w_grant_i) begin
                r_addr   <= i_address;
                r_write  <= 1'b0;
                r_starve <= 2'd0;
            end
        end
    end

    // Next state: arbitrate in IDLE, leave SERVE on the memory response
    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE: begin
                if (w_d_req && !w_i_forced)
                    w_next = SERVE_D;
                else if (i_read)
                    w_next = SERVE_I;
            end
            SERVE_I, SERVE_D: begin
                if (pmem_resp)
                    w_next = IDLE;
            end
            default: w_next = IDLE;
        endcase
    end

    // Outputs: memory driven purely from latches; resp only from the owning state
    always_comb begin
        pmem_read    = 1'b0;
        pmem_write   = 1'b0;
        pmem_address = r_addr;
        pmem_wdata   = r_wdata;
        i_resp       = 1'b0;
        d_resp       = 1'b0;
        i_rdata      = pmem_rdata;
        d_rdata      = pmem_rdata;
        case (r_state)
            SERVE_I: begin
                pmem_read = 1'b1;
                i_resp    = pmem_resp;
            end
            SERVE_D: begin
                pmem_read  = !r_write;
                pmem_write = r_write;
                d_resp     = pmem_resp;
            end
            default: ;
        endcase
    end

endmodule
